// File: rtl/complex_divide.sv
// Sequential fixed-point complex divider: (a+jb)/(c+jd), one quotient bit per cycle for both parts.
// Optional macro COMPLEX_DIVIDE_ROUND_EN: round to nearest (ties away from zero), one extra cycle.
module complex_divide #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 14
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic signed [DATA_WIDTH-1:0] i_num_in,
    input  logic signed [DATA_WIDTH-1:0] q_num_in,
    input  logic signed [DATA_WIDTH-1:0] i_den_in,
    input  logic signed [DATA_WIDTH-1:0] q_den_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic signed [DATA_WIDTH-1:0] i_out,
    output logic signed [DATA_WIDTH-1:0] q_out,
    output logic                         valid_out,
    output logic                         div_by_zero_out
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * W + 1;
`ifdef COMPLEX_DIVIDE_ROUND_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int QB = W + EXTRA;
    localparam int YW = PW + FRAC_BITS + EXTRA;
    localparam int OW = PW + FRAC_BITS + W;
    localparam int CW = $clog2(QB + 1);

    localparam logic [W:0]   POS_MAX_MAG = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0]   NEG_MAX_MAG = {2'b01, {(W-1){1'b0}}};
    localparam logic [W-1:0] POS_SAT     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_SAT     = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, DIVIDE, DONE} state_t;

    state_t                state_q;
    logic signed [W-1:0]   a_q, b_q, c_q, d_q;
    logic [PW-1:0]         den_q;
    logic [PW-1:0]         rem_re_q, rem_im_q;
    logic [QB-1:0]         low_re_q, low_im_q;
    logic [QB-1:0]         quo_re_q, quo_im_q;
    logic                  neg_re_q, neg_im_q, ovf_re_q, ovf_im_q, dbz_q;
    logic [CW-1:0]         cnt_q;
    logic signed [W-1:0]   i_q, q_q;
    logic                  valid_q, dbz_out_q;

    logic signed [PW-1:0]  a_x, b_x, c_x, d_x, nre_d, nim_d;
    logic [PW-1:0]         den_d, mag_re_d, mag_im_d;
    logic [YW-1:0]         y_re_d, y_im_d;
    logic [PW:0]           step_re_d, step_im_d;

    assign a_x      = PW'(a_q);
    assign b_x      = PW'(b_q);
    assign c_x      = PW'(c_q);
    assign d_x      = PW'(d_q);
    assign nre_d    = a_x * c_x + b_x * d_x;
    assign nim_d    = b_x * c_x - a_x * d_x;
    assign den_d    = $unsigned(c_x * c_x + d_x * d_x);
    assign mag_re_d = nre_d[PW-1] ? $unsigned(-nre_d) : $unsigned(nre_d);
    assign mag_im_d = nim_d[PW-1] ? $unsigned(-nim_d) : $unsigned(nim_d);
    assign y_re_d   = {mag_re_d, {(FRAC_BITS + EXTRA){1'b0}}};
    assign y_im_d   = {mag_im_d, {(FRAC_BITS + EXTRA){1'b0}}};

    // Quotient would need more than W integer-result bits: saturate without dividing.
    function automatic logic overflows(input logic [PW-1:0] mag, input logic [PW-1:0] den);
        return (OW'(mag) << FRAC_BITS) >= (OW'(den) << W);
    endfunction

    // Restoring-division step: returns {quotient bit, new remainder}.
    function automatic logic [PW:0] div_step(input logic [PW-1:0] rem, input logic bit_in,
                                             input logic [PW-1:0] den);
        logic [PW:0] t;
        t = {rem, bit_in};
        if (t >= {1'b0, den}) begin
            t = t - {1'b0, den};
            return {1'b1, t[PW-1:0]};
        end
        return {1'b0, t[PW-1:0]};
    endfunction

    function automatic logic [W-1:0] finish(input logic [QB-1:0] quo, input logic neg,
                                            input logic ovf);
        logic [W:0] mag;
        logic [W:0] negv;
`ifdef COMPLEX_DIVIDE_ROUND_EN
        logic [QB:0] ext;
        ext = ({1'b0, quo} + (QB+1)'(1)) >> 1;
        mag = ext[W:0];
`else
        mag = {1'b0, quo};
`endif
        negv = -mag;
        if (neg) begin
            if (ovf || mag > NEG_MAX_MAG) return NEG_SAT;
            return negv[W-1:0];
        end
        if (ovf || mag > POS_MAX_MAG) return POS_SAT;
        return mag[W-1:0];
    endfunction

    assign step_re_d = div_step(rem_re_q, low_re_q[QB-1], den_q);
    assign step_im_d = div_step(rem_im_q, low_im_q[QB-1], den_q);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            den_q     <= '0;
            rem_re_q  <= '0;
            rem_im_q  <= '0;
            low_re_q  <= '0;
            low_im_q  <= '0;
            quo_re_q  <= '0;
            quo_im_q  <= '0;
            neg_re_q  <= 1'b0;
            neg_im_q  <= 1'b0;
            ovf_re_q  <= 1'b0;
            ovf_im_q  <= 1'b0;
            dbz_q     <= 1'b0;
            cnt_q     <= '0;
            i_q       <= '0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        a_q     <= i_num_in;
                        b_q     <= q_num_in;
                        c_q     <= i_den_in;
                        d_q     <= q_den_in;
                        state_q <= MULT;
                    end
                end
                MULT: begin
                    den_q    <= den_d;
                    rem_re_q <= PW'(y_re_d >> QB);
                    rem_im_q <= PW'(y_im_d >> QB);
                    low_re_q <= y_re_d[QB-1:0];
                    low_im_q <= y_im_d[QB-1:0];
                    quo_re_q <= '0;
                    quo_im_q <= '0;
                    neg_re_q <= nre_d[PW-1];
                    neg_im_q <= nim_d[PW-1];
                    ovf_re_q <= overflows(mag_re_d, den_d);
                    ovf_im_q <= overflows(mag_im_d, den_d);
                    dbz_q    <= (den_d == '0);
                    cnt_q    <= '0;
                    state_q  <= DIVIDE;
                end
                DIVIDE: begin
                    rem_re_q <= step_re_d[PW-1:0];
                    rem_im_q <= step_im_d[PW-1:0];
                    quo_re_q <= {quo_re_q[QB-2:0], step_re_d[PW]};
                    quo_im_q <= {quo_im_q[QB-2:0], step_im_d[PW]};
                    low_re_q <= low_re_q << 1;
                    low_im_q <= low_im_q << 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(QB - 1)) state_q <= DONE;
                end
                DONE: begin
                    i_q       <= dbz_q ? '0 : finish(quo_re_q, neg_re_q, ovf_re_q);
                    q_q       <= dbz_q ? '0 : finish(quo_im_q, neg_im_q, ovf_im_q);
                    dbz_out_q <= dbz_q;
                    valid_q   <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_out       = (state_q == IDLE);
    assign i_out           = i_q;
    assign q_out           = q_q;
    assign valid_out       = valid_q;
    assign div_by_zero_out = dbz_out_q;

endmodule
